// File: rtl/axi_dma_data_gen_stream_if.sv
// Bus bundle for axi_dma_data_gen_stream: AXI4-Lite configuration port plus AXI4-Stream output.
// slave = generator side, master = host/driver side.
interface axi_dma_data_gen_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] S_AXI_AWADDR;
  logic              S_AXI_AWVALID;
  logic              S_AXI_AWREADY;
  logic [31:0]       S_AXI_WDATA;
  logic [3:0]        S_AXI_WSTRB;
  logic              S_AXI_WVALID;
  logic              S_AXI_WREADY;
  logic [1:0]        S_AXI_BRESP;
  logic              S_AXI_BVALID;
  logic              S_AXI_BREADY;
  logic [ADDR_W-1:0] S_AXI_ARADDR;
  logic              S_AXI_ARVALID;
  logic              S_AXI_ARREADY;
  logic [31:0]       S_AXI_RDATA;
  logic [1:0]        S_AXI_RRESP;
  logic              S_AXI_RVALID;
  logic              S_AXI_RREADY;
  logic [DATA_W-1:0] M_AXIS_TDATA;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY;
  logic              M_AXIS_TLAST;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, M_AXIS_TREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, M_AXIS_TREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
  );
endinterface

// File: rtl/axi_dma_data_gen_stream.sv
// AXI4-Lite configured AXI4-Stream packet generator (counter / Galois LFSR patterns).
// Optional done interrupt enabled by defining DATA_GEN_IRQ_EN.
module axi_dma_data_gen_stream #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DEF_PKT_LEN = 16
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
`ifdef DATA_GEN_IRQ_EN
  output logic                     IRQ,
`endif
  axi_dma_data_gen_stream_if.slave bus
);
  localparam int unsigned LANES     = DATA_W / 32;
  localparam int unsigned IDX_W     = ADDR_W - 2;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            r_state, w_state_d;
  logic              r_bvalid, r_rvalid;
  logic [31:0]       r_rdata, w_rdata_d;
  logic              r_cont, r_mode, r_mode_sh;
  logic [15:0]       r_pkt_len, r_len, r_beat_cnt, r_pkt_cnt;
  logic [31:0]       r_seed, r_pat;
  logic              w_wr_fire, w_rd_fire, w_ctrl_wr, w_start, w_load;
  logic              w_fire, w_last, w_done, w_pkt_end;
  logic [IDX_W-1:0]  w_widx, w_ridx;
  logic [DATA_W-1:0] w_tdata;
  logic              w_unused_addr;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

  assign w_widx        = bus.S_AXI_AWADDR[ADDR_W-1:2];
  assign w_ridx        = bus.S_AXI_ARADDR[ADDR_W-1:2];
  assign w_unused_addr = ^{bus.S_AXI_AWADDR[1:0], bus.S_AXI_ARADDR[1:0]};

  assign w_wr_fire = bus.S_AXI_AWVALID & bus.S_AXI_WVALID & ~r_bvalid;
  assign w_rd_fire = bus.S_AXI_ARVALID & ~r_rvalid;
  assign w_ctrl_wr = w_wr_fire & (w_widx == IDX_W'(0)) & bus.S_AXI_WSTRB[0];
  assign w_start   = w_ctrl_wr & bus.S_AXI_WDATA[0];
  assign w_load    = w_start & (r_state == StIdle);
  assign w_pkt_end = w_fire & w_last & ~r_cont;

  // AXI4-Lite handshake and response channels
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_bvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_wr_fire)              r_bvalid <= 1'b1;
      else if (bus.S_AXI_BREADY)  r_bvalid <= 1'b0;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_d;
      end else if (bus.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_cont    <= 1'b0;
      r_mode    <= 1'b0;
      r_pkt_len <= 16'(DEF_PKT_LEN);
      r_seed    <= '0;
    end else if (w_wr_fire) begin
      if (w_ctrl_wr) begin
        r_cont <= bus.S_AXI_WDATA[1] & ~bus.S_AXI_WDATA[3];
        r_mode <= bus.S_AXI_WDATA[2];
      end
      if (w_widx == IDX_W'(1)) begin
        for (int b = 0; b < 2; b++) begin
          if (bus.S_AXI_WSTRB[b]) r_pkt_len[b*8 +: 8] <= bus.S_AXI_WDATA[b*8 +: 8];
        end
      end
      if (w_widx == IDX_W'(2)) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.S_AXI_WSTRB[b]) r_seed[b*8 +: 8] <= bus.S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    w_rdata_d = '0;
    if (w_ridx == IDX_W'(0)) w_rdata_d = {29'd0, r_mode, r_cont, 1'b0};
    if (w_ridx == IDX_W'(1)) w_rdata_d = {16'd0, r_pkt_len};
    if (w_ridx == IDX_W'(2)) w_rdata_d = r_seed;
    if (w_ridx == IDX_W'(3)) w_rdata_d = {r_pkt_cnt, 14'd0, w_done, r_state == StRun};
  end

`ifdef DATA_GEN_IRQ_EN
  logic r_done_irq;
  logic w_irq_clr;

  assign w_irq_clr = w_wr_fire & (w_widx == IDX_W'(3)) & bus.S_AXI_WSTRB[0] & bus.S_AXI_WDATA[1];

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                      r_done_irq <= 1'b0;
    else if (w_pkt_end)              r_done_irq <= 1'b1;
    else if (w_load || w_irq_clr)    r_done_irq <= 1'b0;
  end

  assign w_done = r_done_irq;
  assign IRQ    = r_done_irq;
`else
  assign w_done = 1'b0;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_fire    = 1'b0;
    w_last    = 1'b0;
    unique case (r_state)
      StIdle: if (w_load) w_state_d = StRun;
      StRun: begin
        w_fire = bus.M_AXIS_TREADY;
        w_last = (r_beat_cnt == r_len - 16'd1);
        if (w_pkt_end) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Pattern state is reseeded only on START; it free-runs across packets in continuous mode.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_len      <= 16'd1;
      r_mode_sh  <= 1'b0;
      r_pat      <= '0;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_load) begin
      r_len      <= (r_pkt_len == 16'd0) ? 16'd1 : r_pkt_len;
      r_mode_sh  <= bus.S_AXI_WDATA[2];
      r_pat      <= (bus.S_AXI_WDATA[2] && r_seed == 32'd0) ? 32'd1 : r_seed;
      r_beat_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_fire) begin
      r_pat <= r_mode_sh ? lfsr_step(r_pat) : r_pat + 32'd1;
      if (w_last) begin
        r_beat_cnt <= '0;
        if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_tdata = '0;
    if (r_state == StRun) begin
      for (int k = 0; k < int'(LANES); k++) begin
        w_tdata[k*32 +: 32] = r_mode_sh ? r_pat : r_pat * 32'(LANES) + 32'(k);
      end
    end
  end

  assign bus.S_AXI_AWREADY = w_wr_fire;
  assign bus.S_AXI_WREADY  = w_wr_fire;
  assign bus.S_AXI_BRESP   = 2'b00;
  assign bus.S_AXI_BVALID  = r_bvalid;
  assign bus.S_AXI_ARREADY = w_rd_fire;
  assign bus.S_AXI_RDATA   = r_rdata;
  assign bus.S_AXI_RRESP   = 2'b00;
  assign bus.S_AXI_RVALID  = r_rvalid;
  assign bus.M_AXIS_TDATA  = w_tdata;
  assign bus.M_AXIS_TVALID = (r_state == StRun);
  assign bus.M_AXIS_TLAST  = (r_state == StRun) & w_last;
endmodule

// File: tb/tb_axi_dma_data_gen_stream.sv
// Self-checking bench for axi_dma_data_gen_stream (DATA_W=64, two lanes), randomized stimulus
// against a behavioural pattern model. Define DATA_GEN_IRQ_EN to cover the interrupt build.
module tb_axi_dma_data_gen_stream;
  logic ACLK = 1'b0;
  logic ARESET;
`ifdef DATA_GEN_IRQ_EN
  logic IRQ;
`endif

  always #5 ACLK = ~ACLK;

  axi_dma_data_gen_stream_if #(.DATA_W(64), .ADDR_W(4)) bus ();

  axi_dma_data_gen_stream #(.DATA_W(64), .ADDR_W(4), .DEF_PKT_LEN(16)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
`ifdef DATA_GEN_IRQ_EN
    .IRQ    (IRQ),
`endif
    .bus    (bus)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_stab_err = 0;
  logic [63:0] q_data[$];
  logic        q_last[$];
  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [63:0] p_data = '0;

  // Expected beat n of a packet stream started with the given seed.
  function automatic logic [63:0] exp_beat(input bit lfsr, input logic [31:0] seed, input int n);
    logic [31:0] v;
    if (lfsr) begin
      v = (seed == 32'd0) ? 32'd1 : seed;
      for (int i = 0; i < n; i++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
      return {v, v};
    end
    v = seed + 32'(n);
    return {v * 32'd2 + 32'd1, v * 32'd2};
  endfunction

  // Stream monitor: records accepted beats and flags stall instability / unhandshaken drops.
  always @(negedge ACLK) begin
    if (ARESET) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && !(p_ready && p_last) && bus.M_AXIS_TVALID !== 1'b1) n_stab_err++;
      if (p_valid && !p_ready && (bus.M_AXIS_TDATA !== p_data || bus.M_AXIS_TLAST !== p_last))
        n_stab_err++;
      if (bus.M_AXIS_TVALID === 1'b1 && bus.M_AXIS_TREADY === 1'b1) begin
        q_data.push_back(bus.M_AXIS_TDATA);
        q_last.push_back(bus.M_AXIS_TLAST);
      end
      p_valid = (bus.M_AXIS_TVALID === 1'b1);
      p_ready = bus.M_AXIS_TREADY;
      p_data  = bus.M_AXIS_TDATA;
      p_last  = bus.M_AXIS_TLAST;
    end
  end

  task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int t = 0;
    @(posedge ACLK); #1;
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
    #4;
    while (bus.S_AXI_AWREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #5; t++; end
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    while (bus.S_AXI_BVALID !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    if (t >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL axil_write_timeout addr=%h got no response, required BVALID", addr);
    end
  endtask

  task automatic axil_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    @(posedge ACLK); #1;
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1;
    #4;
    while (bus.S_AXI_ARREADY !== 1'b1 && t < 50) begin @(posedge ACLK); #5; t++; end
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
    while (bus.S_AXI_RVALID !== 1'b1 && t < 50) begin @(posedge ACLK); #1; t++; end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    if (t >= 50) begin
      n_cmp++; n_fail++;
      $display("FAIL axil_read_timeout addr=%h got no data, required RVALID", addr);
    end
  endtask

  task automatic run_until_idle(input int nbeats, input bit rnd);
    int t = 0;
    while (!(q_data.size() >= nbeats && bus.M_AXIS_TVALID === 1'b0) && t < 2000) begin
      bus.M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge ACLK); #1; t++;
    end
    bus.M_AXIS_TREADY = 1'b0;
    if (t >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout beats=%0d required %0d then TVALID=0", q_data.size(), nbeats);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, w;
    logic [1:0]  r;
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    n_cmp++;
    if (bus.M_AXIS_TVALID !== 1'b0 || bus.M_AXIS_TLAST !== 1'b0 || bus.M_AXIS_TDATA !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_stream got v=%b l=%b d=%h required 0", bus.M_AXIS_TVALID,
               bus.M_AXIS_TLAST, bus.M_AXIS_TDATA);
    end
    n_cmp++;
    if (bus.S_AXI_BVALID !== 1'b0 || bus.S_AXI_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_axil got bvalid=%b rvalid=%b required 0", bus.S_AXI_BVALID, bus.S_AXI_RVALID);
    end
    ARESET = 1'b0;
    axil_read(4'h4, d, r);
    n_cmp++; if (d !== 32'd16) begin n_fail++; $display("FAIL reset_pkt_len got %h required 10", d); end
    n_cmp++; if (r !== 2'b00) begin n_fail++; $display("FAIL rresp got %b required 00", r); end
    axil_read(4'hC, d, r);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h required 0", d); end
    axil_read(4'h0, d, r);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl got %h required 0", d); end
    axil_write(4'h8, 32'hA5A5_A5A5, 4'hF);
    n_cmp++;
    if (bus.S_AXI_BRESP !== 2'b00) begin n_fail++; $display("FAIL bresp got %b required 00", bus.S_AXI_BRESP); end
    axil_read(4'h8, d, r);
    n_cmp++; if (d !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL seed_rb got %h required a5a5a5a5", d); end
    w = $urandom;
    axil_write(4'h8, w, 4'b0101);
    axil_read(4'h8, d, r);
    n_cmp++;
    if (d !== {8'hA5, w[23:16], 8'hA5, w[7:0]}) begin
      n_fail++; $display("FAIL seed_strobe got %h required %h", d, {8'hA5, w[23:16], 8'hA5, w[7:0]});
    end
  endtask

  task automatic test_counter();
    logic [31:0] d, seed, exp_st;
    logic [1:0]  r;
    q_data.delete(); q_last.delete();
    bus.M_AXIS_TREADY = 1'b0;
    axil_write(4'h8, 32'd0, 4'hF);
    axil_write(4'h4, 32'd4, 4'hF);
    axil_write(4'h0, 32'h1, 4'hF);
    n_cmp++;
    if (bus.M_AXIS_TVALID !== 1'b1 || bus.M_AXIS_TDATA !== 64'h1_0000_0000) begin
      n_fail++; $display("FAIL ctr_first got v=%b d=%h required 1 100000000", bus.M_AXIS_TVALID,
                         bus.M_AXIS_TDATA);
    end
    run_until_idle(4, 1'b0);
    n_cmp++;
    if (q_data.size() != 4) begin n_fail++; $display("FAIL ctr_beats got %0d required 4", q_data.size()); end
    foreach (q_data[i]) begin
      n_cmp++;
      if (q_data[i] !== exp_beat(1'b0, 32'd0, i) || q_last[i] !== (i == 3)) begin
        n_fail++; $display("FAIL ctr_beat%0d got %h/%b required %h/%b", i, q_data[i], q_last[i],
                           exp_beat(1'b0, 32'd0, i), (i == 3));
      end
    end
`ifdef DATA_GEN_IRQ_EN
    exp_st = 32'h0001_0002;
`else
    exp_st = 32'h0001_0000;
`endif
    axil_read(4'hC, d, r);
    n_cmp++; if (d !== exp_st) begin n_fail++; $display("FAIL ctr_status got %h required %h", d, exp_st); end
    axil_read(4'h0, d, r);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL ctr_start_rd got %h required 0", d); end
    // Length 0 behaves as a single-beat packet.
    seed = $urandom;
    q_data.delete(); q_last.delete();
    axil_write(4'h8, seed, 4'hF);
    axil_write(4'h4, 32'd0, 4'h3);
    axil_write(4'h0, 32'h1, 4'h1);
    run_until_idle(1, 1'b1);
    n_cmp++;
    if (q_data.size() != 1 || q_data[0] !== exp_beat(1'b0, seed, 0) || q_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL len0 got n=%0d d=%h required 1 beat %h", q_data.size(),
                         (q_data.size() > 0) ? q_data[0] : 64'd0, exp_beat(1'b0, seed, 0));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] seed;
    seed = $urandom;
    q_data.delete(); q_last.delete();
    n_stab_err = 0;
    axil_write(4'h8, seed, 4'hF);
    axil_write(4'h4, 32'd5, 4'hF);
    axil_write(4'h0, 32'h1, 4'hF);
    run_until_idle(5, 1'b1);
    n_cmp++;
    if (q_data.size() != 5) begin n_fail++; $display("FAIL bp_beats got %0d required 5", q_data.size()); end
    foreach (q_data[i]) begin
      n_cmp++;
      if (q_data[i] !== exp_beat(1'b0, seed, i) || q_last[i] !== (i == 4)) begin
        n_fail++; $display("FAIL bp_beat%0d got %h/%b required %h/%b", i, q_data[i], q_last[i],
                           exp_beat(1'b0, seed, i), (i == 4));
      end
    end
    n_cmp++;
    if (n_stab_err != 0) begin n_fail++; $display("FAIL bp_stable got %0d errors required 0", n_stab_err); end
  endtask

  task automatic test_cont_stop();
    logic [31:0] seed, d;
    logic [1:0]  r;
    int          t = 0;
    seed = $urandom;
    q_data.delete(); q_last.delete();
    n_stab_err = 0;
    bus.M_AXIS_TREADY = 1'b0;
    axil_write(4'h8, seed, 4'hF);
    axil_write(4'h4, 32'd3, 4'hF);
    axil_write(4'h0, 32'h3, 4'hF);
    while (q_data.size() < 4 && t < 100) begin bus.M_AXIS_TREADY = 1'b1; @(posedge ACLK); #1; t++; end
    bus.M_AXIS_TREADY = 1'b0;
    axil_write(4'h0, 32'h8, 4'h1);
    run_until_idle(6, 1'b1);
    n_cmp++;
    if (q_data.size() != 6) begin n_fail++; $display("FAIL cont_beats got %0d required 6", q_data.size()); end
    foreach (q_data[i]) begin
      n_cmp++;
      if (q_data[i] !== exp_beat(1'b0, seed, i) || q_last[i] !== (i % 3 == 2)) begin
        n_fail++; $display("FAIL cont_beat%0d got %h/%b required %h/%b", i, q_data[i], q_last[i],
                           exp_beat(1'b0, seed, i), (i % 3 == 2));
      end
    end
    axil_read(4'hC, d, r);
    n_cmp++;
    if (d[31:16] !== 16'd2 || d[0] !== 1'b0) begin
      n_fail++; $display("FAIL cont_status got %h required pkt_cnt 2 idle", d);
    end
    n_cmp++;
    if (n_stab_err != 0) begin n_fail++; $display("FAIL cont_nogap got %0d errors required 0", n_stab_err); end
  endtask

  task automatic test_lfsr();
    logic [31:0] seed, d;
    logic [1:0]  r;
    int          len;
    len = int'($urandom_range(3, 6));
    q_data.delete(); q_last.delete();
    bus.M_AXIS_TREADY = 1'b0;
    axil_write(4'h8, 32'd0, 4'hF);
    axil_write(4'h4, 32'(len), 4'hF);
    axil_write(4'h0, 32'h5, 4'hF);
    n_cmp++;
    if (bus.M_AXIS_TDATA !== 64'h0000_0001_0000_0001) begin
      n_fail++; $display("FAIL lfsr_first got %h required 0000000100000001", bus.M_AXIS_TDATA);
    end
    axil_write(4'h4, 32'd2, 4'hF);
    axil_write(4'h0, 32'h1, 4'hF);
    run_until_idle(len, 1'b1);
    n_cmp++;
    if (q_data.size() != len) begin n_fail++; $display("FAIL lfsr_beats got %0d required %0d", q_data.size(), len); end
    n_cmp++;
    if (q_data.size() > 1 && q_data[1] !== 64'h8020_0003_8020_0003) begin
      n_fail++; $display("FAIL lfsr_second got %h required 8020000380200003", q_data[1]);
    end
    foreach (q_data[i]) begin
      n_cmp++;
      if (q_data[i] !== exp_beat(1'b1, 32'd0, i) || q_last[i] !== (i == len - 1)) begin
        n_fail++; $display("FAIL lfsr_beat%0d got %h/%b required %h/%b", i, q_data[i], q_last[i],
                           exp_beat(1'b1, 32'd0, i), (i == len - 1));
      end
    end
    axil_read(4'h4, d, r);
    n_cmp++; if (d !== 32'd2) begin n_fail++; $display("FAIL lfsr_len_rd got %h required 2", d); end
    seed = $urandom | 32'h1;
    q_data.delete(); q_last.delete();
    axil_write(4'h8, seed, 4'hF);
    axil_write(4'h0, 32'h5, 4'hF);
    run_until_idle(2, 1'b1);
    n_cmp++;
    if (q_data.size() != 2 || q_data[0] !== exp_beat(1'b1, seed, 0) || q_data[1] !== exp_beat(1'b1, seed, 1)
        || q_last[1] !== 1'b1) begin
      n_fail++; $display("FAIL lfsr_reseed got n=%0d required %h %h", q_data.size(),
                         exp_beat(1'b1, seed, 0), exp_beat(1'b1, seed, 1));
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic [1:0]  r;
    q_data.delete(); q_last.delete();
    axil_write(4'h4, 32'd2, 4'hF);
    axil_write(4'h0, 32'h1, 4'hF);
    run_until_idle(2, 1'b0);
    axil_read(4'hC, d, r);
`ifdef DATA_GEN_IRQ_EN
    n_cmp++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b required 1", IRQ); end
    n_cmp++; if (d[1] !== 1'b1) begin n_fail++; $display("FAIL irq_status got %h required bit1 set", d); end
    axil_write(4'hC, 32'h2, 4'h1);
    n_cmp++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b required 0", IRQ); end
`else
    n_cmp++; if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL noirq_status got %h required 00010000", d); end
`endif
  endtask

  task automatic test_reset_midrun();
    logic [31:0] d;
    logic [1:0]  r;
    q_data.delete(); q_last.delete();
    bus.M_AXIS_TREADY = 1'b0;
    axil_write(4'h4, 32'd8, 4'hF);
    axil_write(4'h0, 32'h3, 4'hF);
    bus.M_AXIS_TREADY = 1'b1;
    repeat (3) begin @(posedge ACLK); #1; end
    #2 ARESET = 1'b1;
    #1;
    n_cmp++;
    if (bus.M_AXIS_TVALID !== 1'b0 || bus.M_AXIS_TLAST !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got tvalid=%b required 0", bus.M_AXIS_TVALID);
    end
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    bus.M_AXIS_TREADY = 1'b0;
    axil_read(4'h4, d, r);
    n_cmp++; if (d !== 32'd16) begin n_fail++; $display("FAIL rst2_len got %h required 10", d); end
    axil_read(4'hC, d, r);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst2_status got %h required 0", d); end
    axil_read(4'h0, d, r);
    n_cmp++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst2_ctrl got %h required 0", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1; bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1; bus.M_AXIS_TREADY = 1'b0;
    test_reset();
    test_counter();
    test_backpressure();
    test_cont_stop();
    test_lfsr();
    test_irq();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
